// File: rtl/sw_poll_ctrl.sv
// Switch PIO poller: periodic Avalon-MM reads, debounce, sticky edge capture and IRQ.
// Build option: define SW_POLL_BOTH_EDGES_EN to capture falling as well as rising changes.
module sw_poll_ctrl #(
    parameter int DATA_W     = 4,
    parameter int POLL_DIV   = 50000,
    parameter int STABLE_CNT = 4,
    parameter int PIO_ADDR   = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq
);

    localparam int                DIV_W    = $clog2(POLL_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(POLL_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [3:0]        CNT_MAX  = 4'(STABLE_CNT);
    localparam logic [DATA_W-1:0] ZERO_D   = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_EVAL = 2'd3
    } state_t;

    state_t            state_r;
    logic [DIV_W-1:0]  div_r;
    logic [3:0]        stab_cnt_r;
    logic              primed_r;
    logic              m_read_r;
    logic [DATA_W-1:0] sample_r;
    logic [DATA_W-1:0] cand_r;
    logic [DATA_W-1:0] deb_r;
    logic [DATA_W-1:0] edge_r;
    logic [DATA_W-1:0] mask_r;
    logic [1:0]        ctrl_r;
    logic [31:0]       s_readdata_r;

    logic              enable_s;
    logic              accept_req_s;
    logic [DATA_W-1:0] next_cand_s;
    logic [3:0]        next_cnt_s;
    logic              take_s;
    logic [DATA_W-1:0] edge_set_s;
    logic [DATA_W-1:0] w1c_s;
    logic              unused_bits_s;

    function automatic logic [DATA_W-1:0] edge_bits(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v);
`ifdef SW_POLL_BOTH_EDGES_EN
        edge_bits = old_v ^ new_v;
`else
        edge_bits = ~old_v & new_v;
`endif
    endfunction

    // Debounce decision for the EVAL cycle, edge set mask and software W1C mask.
    always_comb begin
        enable_s     = ctrl_r[0];
        accept_req_s = m_read_r && !m_waitrequest;
        if (sample_r == cand_r) begin
            next_cand_s = cand_r;
            next_cnt_s  = (stab_cnt_r >= CNT_MAX) ? CNT_MAX : (stab_cnt_r + 4'd1);
        end else begin
            next_cand_s = sample_r;
            next_cnt_s  = 4'd1;
        end
        // Before priming, the first stable value is loaded even if it equals the reset state.
        take_s = (state_r == ST_EVAL) && (next_cnt_s == CNT_MAX) &&
                 (!primed_r || (next_cand_s != deb_r));
        if (take_s && primed_r) begin
            edge_set_s = edge_bits(deb_r, next_cand_s);
        end else begin
            edge_set_s = ZERO_D;
        end
        if (s_write && (s_address == 2'd2)) begin
            w1c_s = s_writedata[DATA_W-1:0];
        end else begin
            w1c_s = ZERO_D;
        end
    end

    // Poll sequencer: divider, Avalon read master and debounce state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            div_r      <= DIV_ZERO;
            stab_cnt_r <= 4'd0;
            primed_r   <= 1'b0;
            m_read_r   <= 1'b0;
            sample_r   <= ZERO_D;
            cand_r     <= ZERO_D;
            deb_r      <= ZERO_D;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!enable_s) begin
                        div_r      <= DIV_ZERO;
                        stab_cnt_r <= 4'd0;
                        primed_r   <= 1'b0;
                    end else if (div_r == DIV_LAST) begin
                        div_r    <= DIV_ZERO;
                        state_r  <= ST_REQ;
                        m_read_r <= 1'b1;
                    end else begin
                        div_r <= div_r + DIV_ONE;
                    end
                end
                ST_REQ: begin
                    // The divider freezes while stalled so stalls stretch the poll period.
                    if (accept_req_s) begin
                        state_r  <= ST_WAIT;
                        m_read_r <= 1'b0;
                        div_r    <= div_r + DIV_ONE;
                    end else begin
                        m_read_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    sample_r <= m_readdata[DATA_W-1:0];
                    state_r  <= ST_EVAL;
                    div_r    <= div_r + DIV_ONE;
                end
                ST_EVAL: begin
                    cand_r     <= next_cand_s;
                    stab_cnt_r <= next_cnt_s;
                    if (take_s) begin
                        deb_r    <= next_cand_s;
                        primed_r <= 1'b1;
                    end
                    state_r <= ST_IDLE;
                    div_r   <= div_r + DIV_ONE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    m_read_r <= 1'b0;
                end
            endcase
        end
    end

    // CSR slave: control/mask writes, sticky edge register and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r       <= 2'd0;
            mask_r       <= ZERO_D;
            edge_r       <= ZERO_D;
            s_readdata_r <= 32'd0;
        end else begin
            if (s_write) begin
                case (s_address)
                    2'd1:    ctrl_r <= s_writedata[1:0];
                    2'd3:    mask_r <= s_writedata[DATA_W-1:0];
                    default: ctrl_r <= ctrl_r;
                endcase
            end
            // Hardware set takes priority over a simultaneous software clear.
            edge_r <= (edge_r & ~w1c_s) | edge_set_s;
            if (s_read) begin
                case (s_address)
                    2'd0:    s_readdata_r <= {{(32-DATA_W){1'b0}}, deb_r};
                    2'd1:    s_readdata_r <= {30'd0, ctrl_r};
                    2'd2:    s_readdata_r <= {{(32-DATA_W){1'b0}}, edge_r};
                    2'd3:    s_readdata_r <= {{(32-DATA_W){1'b0}}, mask_r};
                    default: s_readdata_r <= 32'd0;
                endcase
            end
        end
    end

    assign m_address     = 2'(PIO_ADDR);
    assign m_read        = m_read_r;
    assign s_readdata    = s_readdata_r;
    assign irq           = (|(edge_r & mask_r)) & ctrl_r[1];
    assign unused_bits_s = ^{m_readdata[31:DATA_W], s_writedata[31:DATA_W]};

endmodule

// File: tb/tb_sw_poll_ctrl.sv
// Self-checking bench for sw_poll_ctrl with a latency-1 PIO model and CSR scoreboard.
module tb_sw_poll_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata = 32'h0;
    logic [1:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        irq;

    logic [3:0]  pio_val;
    int          accept_cnt = 0;
    int          checks = 0;
    int          errors = 0;

`ifdef SW_POLL_BOTH_EDGES_EN
    localparam logic [31:0] FALL_EDGE_EXP = 32'h1;
`else
    localparam logic [31:0] FALL_EDGE_EXP = 32'h0;
`endif

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } csr_vec_t;

    exp_t     sb_q[$];
    csr_vec_t vecs[6];

    sw_poll_ctrl #(
        .DATA_W(4),
        .POLL_DIV(8),
        .STABLE_CNT(3),
        .PIO_ADDR(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .m_address(m_address),
        .m_read(m_read),
        .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata),
        .s_address(s_address),
        .s_read(s_read),
        .s_write(s_write),
        .s_writedata(s_writedata),
        .s_readdata(s_readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // PIO slave: data valid only in the cycle after acceptance, junk otherwise.
    always @(posedge clk) begin
        if (m_read && !m_waitrequest) begin
            m_readdata <= {28'hC0FFEE5, pio_val};
            accept_cnt <= accept_cnt + 1;
        end else begin
            m_readdata <= 32'hFFFF_FFF5;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic csr_write(input logic [1:0] addr, input logic [31:0] data);
        s_address   = addr;
        s_writedata = data;
        s_write     = 1'b1;
        @(negedge clk);
        s_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e.exp     = exp;
        e.name    = name;
        s_address = addr;
        s_read    = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        s_read = 1'b0;
        e = sb_q.pop_front();
        check(e.name, s_readdata, e.exp);
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (accept_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (accept_cnt < target) check("poll_timeout", accept_cnt, target);
    endtask

    task automatic wait_polls(input int k);
        wait_acc(accept_cnt + k);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int g;
        int rd_seen;
        int base;

        reset         = 1'b1;
        m_waitrequest = 1'b0;
        s_address     = 2'd0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_writedata   = 32'd0;
        pio_val       = 4'hA;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset_m_read", m_read, 0);
        check("reset_irq", irq, 0);
        check("reset_s_readdata", s_readdata, 0);

        rd_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_read) rd_seen++;
        end
        check("idle_no_read", rd_seen, 0);
        for (int a = 0; a < 4; a++) csr_read(2'(a), 32'h0, $sformatf("reset_csr%0d", a));
        check("idle_irq", irq, 0);

        vecs[0] = '{2'd1, 32'hFFFF_FFFE, 32'h2};
        vecs[1] = '{2'd3, 32'hFFFF_FFF5, 32'h5};
        vecs[2] = '{2'd0, 32'h0000_000F, 32'h0};
        vecs[3] = '{2'd2, 32'h0000_000F, 32'h0};
        vecs[4] = '{2'd1, 32'h0000_0000, 32'h0};
        vecs[5] = '{2'd3, 32'h0000_0000, 32'h0};
        for (int v = 0; v < 6; v++) begin
            csr_write(vecs[v].addr, vecs[v].wdata);
            csr_read(vecs[v].addr, vecs[v].exp, $sformatf("csr_vec%0d", v));
        end
        check("table_irq", irq, 0);

        // Priming: first stable value loads STATE without an edge.
        pio_val = 4'hA;
        csr_write(2'd1, 32'h1);
        base = accept_cnt;
        g = 0;
        while (!m_read && g < 100) begin @(negedge clk); g++; end
        g = 0;
        while (m_read && g < 100) begin @(negedge clk); g++; end
        while (!m_read && g < 100) begin @(negedge clk); g++; end
        check("poll_period", g, 8);
        wait_acc(base + 2);
        repeat (3) @(negedge clk);
        csr_read(2'd0, 32'h0, "state_after_2_polls");
        wait_acc(base + 3);
        repeat (3) @(negedge clk);
        csr_read(2'd0, 32'hA, "state_primed");
        csr_read(2'd2, 32'h0, "edge_primed");

        // Rising edge with IRQ, then W1C.
        csr_write(2'd3, 32'hF);
        csr_write(2'd1, 32'h3);
        check("irq_no_edge", irq, 0);
        pio_val = 4'hB;
        wait_polls(2);
        csr_read(2'd0, 32'hA, "state_before_stable");
        wait_polls(1);
        csr_read(2'd0, 32'hB, "state_rise");
        csr_read(2'd2, 32'h1, "edge_rise");
        check("irq_rise", irq, 1);
        csr_write(2'd2, 32'h1);
        check("irq_after_w1c", irq, 0);

        // Bounce rejection.
        pio_val = 4'h3;
        for (int i = 0; i < 10; i++) begin
            wait_polls(1);
            pio_val = (pio_val == 4'h3) ? 4'hB : 4'h3;
        end
        csr_read(2'd0, 32'hB, "state_bounce");
        csr_read(2'd2, 32'h0, "edge_bounce");
        check("irq_bounce", irq, 0);

        // Waitrequest stall on a poll that samples a new value.
        pio_val       = 4'hF;
        m_waitrequest = 1'b1;
        g = 0;
        while (!m_read && g < 100) begin @(negedge clk); g++; end
        check("stall_req_seen", m_read, 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_m_read", m_read, 1);
            check("stall_addr", m_address, 0);
            @(negedge clk);
        end
        m_waitrequest = 1'b0;
        @(negedge clk);
        check("m_read_drop", m_read, 0);
        g = 1;
        while (!m_read && g < 100) begin @(negedge clk); g++; end
        check("period_after_stall", g, 8);
        wait_polls(2);
        csr_read(2'd0, 32'hF, "state_after_stall");
        csr_read(2'd2, 32'h4, "edge_after_stall");
        check("irq_after_stall", irq, 1);

        // Falling change: captured only when both edges are enabled.
        csr_write(2'd2, 32'hF);
        check("irq_cleared", irq, 0);
        pio_val = 4'hE;
        wait_polls(3);
        csr_read(2'd0, 32'hE, "state_fall");
        csr_read(2'd2, FALL_EDGE_EXP, "edge_fall");
        csr_write(2'd0, 32'h0);
        csr_read(2'd0, 32'hE, "state_ro");

        // Hardware set and W1C on the same bit in the same cycle.
        csr_write(2'd2, 32'hF);
        pio_val = 4'hF;
        wait_polls(2);
        wait_acc(accept_cnt + 1);
        @(negedge clk);
        csr_write(2'd2, 32'h1);
        csr_read(2'd2, 32'h1, "edge_set_wins");
        csr_read(2'd0, 32'hF, "state_collide");
        check("irq_collide", irq, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sw_poll_ctrl.md
Name: sw_poll_ctrl

Overview:
- Autonomous Avalon-MM master that periodically polls the 4-bit switch PIO input (data register, word address 0).
- Debounces the sampled value over consecutive polls.
- Maintains a debounced-state register and a sticky edge-capture register with IRQ.
- Exposes a small Avalon-MM slave for the Nios II, so software no longer busy-polls the switch PIO.

Parameters:
DATA_W, 4, width of switch field taken from bits [DATA_W-1:0] of PIO readdata
POLL_DIV, 50000, clk cycles between poll issues (>=2); counter width = $clog2(POLL_DIV)
STABLE_CNT, 4, consecutive identical samples required to accept a new value (>=1, <=15)
PIO_ADDR, 0, word address driven on m_address

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
m_address  out  2  PIO word address; constant PIO_ADDR
m_read  out  1  read request to PIO
m_waitrequest  in  1  interconnect stall; request is accepted in the cycle m_read=1 and m_waitrequest=0
m_readdata  in  32  PIO read data; valid exactly 1 cycle after acceptance (fixed read latency 1)
s_address  in  2  CSR word address
s_read  in  1  CSR read strobe
s_write  in  1  CSR write strobe
s_writedata  in  32  CSR write data
s_readdata  out  32  CSR read data; registered, latency 1
irq  out  1  level interrupt: |(edge & irq_mask) & ctrl.irq_en

Behaviour:
- Reset (synchronous):
  - m_read=0, s_readdata=0, irq=0.
  - State=IDLE; divider, stability counter, primed flag, state, edge, mask and ctrl all 0.
- CSR map:
  - 0 STATE, RO: debounced value in [DATA_W-1:0].
  - 1 CTRL, RW: bit0 enable, bit1 irq_en.
  - 2 EDGE, W1C: sticky edge bits.
  - 3 MASK, RW: [DATA_W-1:0] irq_mask.
  - Unused bits read 0.
- FSM:
  - IDLE: divider counts up while enable=1 and holds at 0 while enable=0. At POLL_DIV-1, divider wraps to 0 -> REQ.
  - REQ: m_read=1, held stable until accepted. On accept -> WAIT; m_read drops in the next cycle.
  - WAIT: sample = m_readdata[DATA_W-1:0] -> EVAL.
  - EVAL: one cycle, then -> IDLE.
    - If sample==candidate, stab_cnt increments, saturating at STABLE_CNT.
    - Otherwise candidate<=sample and stab_cnt<=1.
    - When stab_cnt reaches STABLE_CNT and candidate!=state: state<=candidate, and edge bits are set for changed bits per Optional Feature.
    - If primed=0, state is loaded without setting edge bits, then primed<=1.
- Poll period: POLL_DIV cycles from one REQ entry to the next, plus any waitrequest stall cycles.
- Enable cleared mid-transaction:
  - An outstanding REQ completes, then IDLE holds.
  - primed and stab_cnt clear when enable=0 is seen in IDLE.
- Simultaneous hardware edge-set and software W1C on the same bit: set wins.
- Writes to RO address 0 are ignored. Simultaneous s_read and s_write: both are serviced.
- irq is combinational from registers; it deasserts in the cycle after W1C clears the last enabled edge.

Optional Feature:
- Macro: SW_POLL_BOTH_EDGES_EN.
- Defined: an edge bit is set on any debounced change (state ^ new).
- Undefined: an edge bit is set only on 0->1 transitions (~state & new). Falling changes update STATE without capture.

Test Plan:
- Reset/idle, POLL_DIV=8, STABLE_CNT=3, enable=0 for 100 cycles -> m_read never asserts; all CSR reads return 0; irq=0.
- Priming: write CTRL=1, PIO returns 4'hA constantly -> m_read pulses every 8 cycles; STATE=0xA after the 3rd poll; EDGE=0.
- Rising edge with IRQ: after priming, MASK=0xF, CTRL=3, PIO changes to 0xB -> STATE=0xB and EDGE=0x1 after 3 polls; irq=1. Write EDGE=0x1 -> irq=0 the next cycle.
- Bounce rejection: PIO alternates 0xB/0x3 per poll for 10 polls -> STATE unchanged, EDGE unchanged.
- Waitrequest stall: hold m_waitrequest=1 for 5 cycles during REQ -> m_read stays high with constant address; sample taken exactly 1 cycle after release; next REQ 8 cycles later.
- Falling edge and macro: 0xB->0xA debounced -> EDGE bit0 set only with SW_POLL_BOTH_EDGES_EN; STATE=0xA in both builds. Set and W1C of the same bit in the same cycle -> bit remains 1.
